// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

   localparam int          ITER    = 32;
   localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } mdu_state_e;

   // Magnitude of a value whose sign bit has already been qualified by its signedness.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      logic signed [31:0] sv;
      sv = v;
      return neg ? 32'(-sv) : v;
   endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Double-width adder/subtractor shared by multiply accumulate, divide trial subtract and FIX negation.
module mdu_addsub #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] sum_o,
   output logic         borrow_o
);

   logic [W:0] full;

   assign full     = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{W{1'b0}}, sub_i};
   assign sum_o    = full[W-1:0];
   // For subtraction a missing carry-out means a < b; for addition it is the plain carry.
   assign borrow_o = sub_i ? ~full[W] : full[W];

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MDU_EARLY_TERM_EN to let multiplies leave CALC once the remaining multiplier is zero.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] RS1,
   input  logic [WIDTH-1:0] RS2,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

   mdu_state_e         state_q;
   mdu_op_e            op_q;
   logic               neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] opa_q;
   logic [WIDTH-1:0]   opb_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;

   mdu_op_e            op_in;
   logic               a_sgn, b_sgn, sa, sb, neg_d;
   logic               div0, ovf, in_is_rem;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               mul_last, calc_last;
   logic [2*WIDTH-1:0] add_a, add_b, add_sum, fix_val, fixed;
   logic               add_sub, add_borrow;
   logic [WIDTH-1:0]   result_d;

   assign op_in     = mdu_op_e'(OP);
   assign a_sgn     = !(op_in inside {MDU_MULHU, MDU_DIVU, MDU_REMU});
   assign b_sgn     = op_in inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
   assign sa        = a_sgn & RS1[WIDTH-1];
   assign sb        = b_sgn & RS2[WIDTH-1];
   assign in_is_rem = OP[2] & OP[1];
   assign neg_d     = in_is_rem ? sa : (sa ^ sb);
   assign abs_a     = mag32(RS1, sa);
   assign abs_b     = mag32(RS2, sb);
   assign div0      = OP[2] && (RS2 == '0);
   assign ovf       = OP[2] && !OP[0] && (RS1 == INT_MIN) && (RS2 == '1);

`ifdef MDU_EARLY_TERM_EN
   assign mul_last  = (opb_q[WIDTH-1:1] == '0);
`else
   assign mul_last  = 1'b0;
`endif
   assign calc_last = (cnt_q == LAST) || (!op_q[2] && mul_last);

   always_comb begin
      fix_val = acc_q;
      if (op_q[2]) begin
         fix_val = op_q[1] ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : {{WIDTH{1'b0}}, opa_q[WIDTH-1:0]};
      end
   end

   // The divide trial keeps the shifted-out remainder bit, so divisors above 2^31 still compare correctly.
   always_comb begin
      add_a   = acc_q;
      add_b   = opb_q[0] ? opa_q : '0;
      add_sub = 1'b0;
      if (state_q == S_CALC && op_q[2]) begin
         add_a   = {{(WIDTH-1){1'b0}}, acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
         add_b   = {{WIDTH{1'b0}}, opb_q};
         add_sub = 1'b1;
      end else if (state_q == S_FIX) begin
         add_a   = '0;
         add_b   = fix_val;
         add_sub = 1'b1;
      end
   end

   mdu_addsub #(.W(2*WIDTH)) u_addsub (
      .a_i      (add_a),
      .b_i      (add_b),
      .sub_i    (add_sub),
      .sum_o    (add_sum),
      .borrow_o (add_borrow)
   );

   assign fixed = neg_q ? add_sum : fix_val;

   always_comb begin
      result_d = fixed[WIDTH-1:0];
      if (!op_q[2] && op_q != MDU_MUL) result_d = fixed[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (START) begin
                  op_q  <= op_in;
                  neg_q <= neg_d;
                  cnt_q <= '0;
                  acc_q <= '0;
                  opa_q <= {{WIDTH{1'b0}}, abs_a};
                  opb_q <= abs_b;
                  if (div0) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= in_is_rem ? RS1 : DIV0_Q;
                  end else if (ovf) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= in_is_rem ? '0 : INT_MIN;
                  end else begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_CALC: begin
               cnt_q <= cnt_q + 1'b1;
               if (op_q[2]) begin
                  acc_q <= add_borrow ? {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], opa_q[WIDTH-1]}
                                      : {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                  opa_q <= {opa_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-2:0], ~add_borrow};
               end else begin
                  acc_q <= add_sum;
                  opa_q <= opa_q << 1;
                  opb_q <= opb_q >> 1;
               end
               if (calc_last) state_q <= S_FIX;
            end
            S_FIX: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected results, a negedge monitor checks each DONE.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET, START;
   logic [2:0]  OP;
   logic [31:0] RS1, RS2;
   logic        BUSY, DONE;
   logic [31:0] RESULT;

   mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .START  (START),
      .OP     (OP),
      .RS1    (RS1),
      .RS2    (RS2),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .RESULT (RESULT)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

`ifdef MDU_EARLY_TERM_EN
   localparam int LAT_SMALL = 4;
`else
   localparam int LAT_SMALL = 34;
`endif

   typedef struct {
      logic [31:0] res;
      int          t0;
      int          lat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   errors = 0;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", n, got, want);
      end
   endtask

   // Latency is counted from the cycle START is driven to the cycle DONE is seen.
   always @(negedge CLK) begin
      exp_t e;
      if (DONE === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_done: got DONE with result %h, want no DONE", RESULT);
         end else begin
            e = exp_q.pop_front();
            chk(e.name, RESULT, e.res);
            chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
            chk({e.name, "_busy_in_done"}, {31'd0, BUSY}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string n);
      exp_t e;
      e.res  = res;
      e.t0   = cyc;
      e.lat  = lat;
      e.name = n;
      exp_q.push_back(e);
      START = 1'b1;
      OP    = op;
      RS1   = a;
      RS2   = b;
      @(negedge CLK);
      START = 1'b0;
      OP    = 3'($urandom);
      RS1   = $urandom;
      RS2   = $urandom;
   endtask

   task automatic wait_done(output int busy_n);
      busy_n = 0;
      for (int i = 0; i < 100; i++) begin
         if (DONE === 1'b1) return;
         if (BUSY === 1'b1) busy_n++;
         @(negedge CLK);
      end
      tests++;
      errors++;
      $display("FAIL done_timeout: got no DONE in 100 cycles, want DONE");
   endtask

   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input int lat, input string n, output int busy_n);
      issue(op, a, b, res, lat, n);
      wait_done(busy_n);
      @(negedge CLK);
   endtask

   initial begin
      int bn;
      int done_seen;
      RESET = 1'b1;
      START = 1'b0;
      OP    = 3'd0;
      RS1   = '0;
      RS2   = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy",   {31'd0, BUSY}, 32'd0);
      chk("rst_done",   {31'd0, DONE}, 32'd0);
      chk("rst_result", RESULT, 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      run(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3", bn);
      chk("mul_busy_cycles", 32'(bn), 32'd33);
      run(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min_min", bn);
      run(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max", bn);
      run(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_SMALL, "mulhsu_m1_2", bn);
      run(MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2", bn);
      run(MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2", bn);
      run(MDU_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu_100_7", bn);
      run(MDU_REMU,   32'd100,       32'd7,         32'd2,         34, "remu_100_7", bn);
      run(MDU_REMU,   32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, "remu_big_divisor", bn);
      run(MDU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by_zero", bn);
      chk("div0_busy_cycles", 32'(bn), 32'd0);
      run(MDU_REM,    32'd5,         32'd0,         32'd5,         1,  "rem_by_zero", bn);
      run(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_overflow", bn);
      run(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_overflow", bn);
      run(MDU_MUL,    32'd5,         32'd3,         32'd15,        LAT_SMALL, "mul_5_3", bn);

      // START during a busy multiply must be dropped.
      issue(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_start_ignored");
      repeat (9) @(negedge CLK);
      START = 1'b1;
      OP    = MDU_DIVU;
      RS1   = 32'd100;
      RS2   = 32'd7;
      @(negedge CLK);
      START = 1'b0;
      wait_done(bn);
      repeat (5) @(negedge CLK);

      // Reset mid-operation aborts without DONE and clears RESULT.
      issue(MDU_MUL, 32'd9, 32'd9, 32'd81, 34, "mul_aborted");
      repeat (13) @(negedge CLK);
      exp_q.delete();
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("abort_busy",   {31'd0, BUSY}, 32'd0);
      chk("abort_done",   {31'd0, DONE}, 32'd0);
      chk("abort_result", RESULT, 32'd0);
      done_seen = 0;
      repeat (40) begin
         @(negedge CLK);
         if (DONE === 1'b1) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);

      // Back-to-back: second START issued in the DONE cycle of the first.
      issue(MDU_DIVU, 32'd100, 32'd7, 32'd14, 34, "b2b_first");
      wait_done(bn);
      issue(MDU_REMU, 32'd100, 32'd7, 32'd2, 34, "b2b_second");
      wait_done(bn);
      repeat (5) @(negedge CLK);

      chk("pending_expectations", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, want completion");
      $fatal(1, "timeout");
   end

endmodule
